// File: rtl/wave_ram_pkg.sv
// Shared defaults and FSM encoding for the wave RAM block.
package wave_ram_pkg;

   localparam int unsigned WAVE_DATA_W = 20;
   localparam int unsigned WAVE_ADDR_W = 12;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } wave_state_e;

endpackage : wave_ram_pkg

// File: rtl/wave_ram_core.sv
// Plain simple-dual-port RAM: one write port, one registered read port.
// No per-word reset, so the array maps onto block RAM.
module ram_core
   import wave_ram_pkg::*;
#(
   parameter int unsigned DATA_W = WAVE_DATA_W,
   parameter int unsigned ADDR_W = WAVE_ADDR_W
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write and registered read share one block so a same-address access returns the old word.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule : ram_core

// File: rtl/wave_ram.sv
// Wave RAM: block RAM with a full-memory clear sweep controlled by a CLEAR/READY FSM.
module wave_ram
   import wave_ram_pkg::*;
#(
   parameter int unsigned DATA_W = WAVE_DATA_W,
   parameter int unsigned ADDR_W = WAVE_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              LOAD,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] sel,
   input  logic [ADDR_W-1:0] rsel,
   input  logic              CLR,
   output logic [DATA_W-1:0] OUT,
   output logic              BUSY
);

   localparam int unsigned       DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   wave_state_e       state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              rd_valid_q, rd_valid_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Next-state logic: sweep every address once, then wait in READY for a clear request.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         CLEAR: begin
            if (clr_addr_q == LAST_ADDR) begin
               state_d = READY;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         READY: begin
            if (CLR) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         default: begin
            state_d    = CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   // Write port mux: sweep writes zeros in CLEAR, user writes only in READY.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = sel;
      ram_wdata = IN;
      if (state_q == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr_q;
         ram_wdata = '0;
      end else if (LOAD) begin
         ram_we    = 1'b1;
      end
   end

   // The RAM read register runs every cycle; this flag marks whether its word was read in READY,
   // which is how OUT is forced to zero for every edge taken in CLEAR and by reset.
   always_comb begin
      rd_valid_d = (state_q == READY);
   end

   // State, sweep address and read-valid registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram_core (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (rsel),
      .rdata_o (ram_rdata)
   );

   assign OUT  = rd_valid_q ? ram_rdata : '0;
   assign BUSY = (state_q == CLEAR);

endmodule : wave_ram
